// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register.
//   - MODE_* : 3-bit operation codes presented on the top-level mode port.
//   - cell_sel_e : per-bit mux select used between the top and usr_bit_cell.
//   - cnt_width() : width of the shift counter for a given register width.
package usr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_ROTR  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;
    localparam logic [2:0] MODE_RSVD  = 3'b111;

    // Per-bit source select. SEL_LO takes the neighbour one position below
    // (left shift / rotate); SEL_HI takes the neighbour one position above.
    typedef enum logic [2:0] {
        SEL_HOLD = 3'd0,
        SEL_LOAD = 3'd1,
        SEL_LO   = 3'd2,
        SEL_HI   = 3'd3,
        SEL_ZERO = 3'd4
    } cell_sel_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_bit_cell.sv
// One storage bit of the universal shift register: a five-way source mux
// feeding an asynchronous-reset D flip-flop.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (bit goes to RST_VAL)
//   sel         : source select (hold / load / lower / upper / zero)
//   load_in     : parallel load bit
//   lo_in       : value from the neighbour below (or left-end wrap/serial)
//   hi_in       : value from the neighbour above (or right-end wrap/serial)
//   q, qn       : stored bit and its complement
module usr_bit_cell
    import usr_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  cell_sel_e sel,
    input  logic      load_in,
    input  logic      lo_in,
    input  logic      hi_in,
    output logic      q,
    output logic      qn
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        case (sel)
            SEL_HOLD: q_d = q_q;
            SEL_LOAD: q_d = load_in;
            SEL_LO:   q_d = lo_in;
            SEL_HI:   q_d = hi_in;
            SEL_ZERO: q_d = 1'b0;
            default:  q_d = q_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RST_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register with hold/load/shift/rotate/clear modes,
// serial I/O at both ends and a saturating shift counter.
// Optional feature: define USR_PARITY_EN to drive parity = ^Q; otherwise
// parity is tied low and no XOR tree exists. Port list is the same either way.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : cycle enable (0 forces hold)
//   mode            : operation select (see usr_pkg MODE_*)
//   D               : parallel load data
//   sin_r, sin_l    : serial inputs into bit 0 (SHL) / bit WIDTH-1 (SHR)
//   Q, Qn           : register state and complement
//   sout_l, sout_r  : Q[WIDTH-1], Q[0]
//   cnt, full       : shifts since last LOAD/CLEAR/reset (saturating), cnt==WIDTH
//   parity          : even-parity indicator of Q (or 0)
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [2:0]                  mode,
    input  logic [WIDTH-1:0]            D,
    input  logic                        sin_r,
    input  logic                        sin_l,
    output logic [WIDTH-1:0]            Q,
    output logic [WIDTH-1:0]            Qn,
    output logic                        sout_l,
    output logic                        sout_r,
    output logic [cnt_width(WIDTH)-1:0] cnt,
    output logic                        full,
    output logic                        parity
);

    localparam int CW = cnt_width(WIDTH);

    cell_sel_e        sel;
    logic             lo_wrap;
    logic             hi_wrap;
    logic             is_shift;
    logic [WIDTH-1:0] lo_in;
    logic [WIDTH-1:0] hi_in;
    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qn_w;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    // Mode decode. Reserved codes and en=0 fall through to hold.
    always_comb begin
        sel      = SEL_HOLD;
        is_shift = 1'b0;
        if (en) begin
            case (mode)
                MODE_LOAD:  sel = SEL_LOAD;
                MODE_SHL,
                MODE_ROTL: begin
                    sel      = SEL_LO;
                    is_shift = 1'b1;
                end
                MODE_SHR,
                MODE_ROTR: begin
                    sel      = SEL_HI;
                    is_shift = 1'b1;
                end
                MODE_CLEAR: sel = SEL_ZERO;
                default:    sel = SEL_HOLD;
            endcase
        end
    end

    // End-of-chain sources: serial input for shifts, opposite end for rotates.
    // With WIDTH=1 the rotate wrap is the bit itself, so ROTL/ROTR hold.
    assign lo_wrap = (mode == MODE_SHL) ? sin_r : q_w[WIDTH-1];
    assign hi_wrap = (mode == MODE_SHR) ? sin_l : q_w[0];

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_lo_end
            assign lo_in[i] = lo_wrap;
        end else begin : g_lo_mid
            assign lo_in[i] = q_w[i-1];
        end

        if (i == WIDTH - 1) begin : g_hi_end
            assign hi_in[i] = hi_wrap;
        end else begin : g_hi_mid
            assign hi_in[i] = q_w[i+1];
        end

        usr_bit_cell #(
            .RST_VAL (RESET_VAL[i])
        ) u_cell (
            .clk     (clk),
            .rst_n   (rst_n),
            .sel     (sel),
            .load_in (D[i]),
            .lo_in   (lo_in[i]),
            .hi_in   (hi_in[i]),
            .q       (q_w[i]),
            .qn      (qn_w[i])
        );
    end

    // Shift counter: cleared by LOAD/CLEAR, saturates at WIDTH.
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (mode == MODE_LOAD || mode == MODE_CLEAR) begin
                cnt_d = '0;
            end else if (is_shift && (cnt_q != CW'(WIDTH))) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign Q      = q_w;
    assign Qn     = qn_w;
    assign sout_l = q_w[WIDTH-1];
    assign sout_r = q_w[0];
    assign cnt    = cnt_q;
    assign full   = (cnt_q == CW'(WIDTH));

`ifdef USR_PARITY_EN
    assign parity = ^q_w;
`else
    assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_universal_shift_register.sv
// Directed bench for universal_shift_register: an 8-bit instance with
// RESET_VAL=A5 and a 1-bit instance with RESET_VAL=0.
module tb_universal_shift_register;
    import usr_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic [7:0] q;
    logic [7:0] qn;
    logic       sout_l;
    logic       sout_r;
    logic [3:0] cnt;
    logic       full;
    logic       parity;

    logic       en1;
    logic [2:0] mode1;
    logic [0:0] d1;
    logic       sin_r1;
    logic       sin_l1;
    logic [0:0] q1;
    logic [0:0] qn1;
    logic       sout_l1;
    logic       sout_r1;
    logic [0:0] cnt1;
    logic       full1;
    logic       parity1;

    int n_checks;
    int n_fail;

    universal_shift_register #(
        .WIDTH     (8),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .mode   (mode),
        .D      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .Q      (q),
        .Qn     (qn),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .cnt    (cnt),
        .full   (full),
        .parity (parity)
    );

    universal_shift_register #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en1),
        .mode   (mode1),
        .D      (d1),
        .sin_r  (sin_r1),
        .sin_l  (sin_l1),
        .Q      (q1),
        .Qn     (qn1),
        .sout_l (sout_l1),
        .sout_r (sout_r1),
        .cnt    (cnt1),
        .full   (full1),
        .parity (parity1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns after.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (q !== 8'hA5) begin n_fail++; $display("FAIL reset_q got=%h exp=a5", q); end
        n_checks++;
        if (qn !== 8'h5A) begin n_fail++; $display("FAIL reset_qn got=%h exp=5a", qn); end
        n_checks++;
        if (cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        n_checks++;
        if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
        n_checks++;
        if (q1 !== 1'b0 || cnt1 !== 1'b0) begin
            n_fail++; $display("FAIL reset_w1 got q=%b cnt=%b exp q=0 cnt=0", q1, cnt1);
        end
        step();
        rst_n = 1'b1;
        en    = 1'b0;
        mode  = MODE_LOAD;
        d     = 8'h00;
        step();
        n_checks++;
        if (q !== 8'hA5) begin n_fail++; $display("FAIL release_hold_q got=%h exp=a5", q); end
    endtask

    task automatic test_shl_count();
        logic [7:0] exp_q [8] = '{8'h79, 8'hF3, 8'hE7, 8'hCF, 8'h9F, 8'h3F, 8'h7F, 8'hFF};
        en   = 1'b1;
        mode = MODE_LOAD;
        d    = 8'h3C;
        step();
        n_checks++;
        if (q !== 8'h3C || cnt !== 4'd0) begin
            n_fail++; $display("FAIL load_3c got q=%h cnt=%0d exp q=3c cnt=0", q, cnt);
        end
        mode  = MODE_SHL;
        sin_r = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            n_checks++;
            if (q !== exp_q[i] || cnt !== 4'(i + 1) || full !== (i == 7)) begin
                n_fail++;
                $display("FAIL shl_%0d got q=%h cnt=%0d full=%b exp q=%h cnt=%0d full=%b",
                         i, q, cnt, full, exp_q[i], i + 1, (i == 7));
            end
        end
        step();
        n_checks++;
        if (q !== 8'hFF || cnt !== 4'd8 || full !== 1'b1) begin
            n_fail++; $display("FAIL shl_sat got q=%h cnt=%0d full=%b exp q=ff cnt=8 full=1", q, cnt, full);
        end
    endtask

    task automatic test_serial();
        mode = MODE_LOAD;
        d    = 8'h81;
        step();
        mode  = MODE_SHR;
        sin_l = 1'b0;
        step();
        n_checks++;
        if (q !== 8'h40 || sout_r !== 1'b0) begin
            n_fail++; $display("FAIL shr got q=%h sout_r=%b exp q=40 sout_r=0", q, sout_r);
        end
        mode = MODE_ROTR;
        step();
        n_checks++;
        if (q !== 8'h20) begin n_fail++; $display("FAIL rotr got=%h exp=20", q); end
        mode = MODE_ROTL;
        step();
        step();
        n_checks++;
        if (q !== 8'h80 || sout_l !== 1'b1) begin
            n_fail++; $display("FAIL rotl2 got q=%h sout_l=%b exp q=80 sout_l=1", q, sout_l);
        end
        step();
        n_checks++;
        if (q !== 8'h01 || sout_l !== 1'b0 || sout_r !== 1'b1 || cnt !== 4'd5) begin
            n_fail++; $display("FAIL rotl_wrap got q=%h sout_l=%b sout_r=%b cnt=%0d exp q=01 0 1 cnt=5",
                               q, sout_l, sout_r, cnt);
        end
    endtask

    task automatic test_gating();
        d    = 8'hFF;
        mode = MODE_RSVD;
        step();
        n_checks++;
        if (q !== 8'h01 || cnt !== 4'd5) begin
            n_fail++; $display("FAIL rsvd got q=%h cnt=%0d exp q=01 cnt=5", q, cnt);
        end
        mode = MODE_HOLD;
        step();
        n_checks++;
        if (q !== 8'h01 || cnt !== 4'd5) begin
            n_fail++; $display("FAIL hold got q=%h cnt=%0d exp q=01 cnt=5", q, cnt);
        end
        en   = 1'b0;
        mode = MODE_LOAD;
        step();
        n_checks++;
        if (q !== 8'h01 || cnt !== 4'd5) begin
            n_fail++; $display("FAIL en0 got q=%h cnt=%0d exp q=01 cnt=5", q, cnt);
        end
        en   = 1'b1;
        mode = MODE_CLEAR;
        step();
        n_checks++;
        if (q !== 8'h00 || qn !== 8'hFF || cnt !== 4'd0 || full !== 1'b0) begin
            n_fail++; $display("FAIL clear got q=%h qn=%h cnt=%0d full=%b exp q=00 qn=ff cnt=0 full=0",
                               q, qn, cnt, full);
        end
    endtask

    task automatic test_async_reset();
        mode = MODE_LOAD;
        d    = 8'h3C;
        step();
        mode  = MODE_SHL;
        sin_r = 1'b0;
        for (int i = 0; i < 5; i++) step();
        n_checks++;
        if (q !== 8'h80 || cnt !== 4'd5) begin
            n_fail++; $display("FAIL pre_async got q=%h cnt=%0d exp q=80 cnt=5", q, cnt);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (q !== 8'hA5 || cnt !== 4'd0 || full !== 1'b0) begin
            n_fail++; $display("FAIL async_rst got q=%h cnt=%0d full=%b exp q=a5 cnt=0 full=0", q, cnt, full);
        end
        en = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        en = 1'b1;
    endtask

    task automatic test_parity();
        mode = MODE_LOAD;
        d    = 8'h07;
        step();
`ifdef USR_PARITY_EN
        n_checks++;
        if (parity !== 1'b1) begin n_fail++; $display("FAIL parity_07 got=%b exp=1", parity); end
`else
        n_checks++;
        if (parity !== 1'b0) begin n_fail++; $display("FAIL parity_off_07 got=%b exp=0", parity); end
`endif
        d = 8'h03;
        step();
        n_checks++;
        if (parity !== 1'b0) begin n_fail++; $display("FAIL parity_03 got=%b exp=0", parity); end
    endtask

    task automatic test_width1();
        en1    = 1'b1;
        mode1  = MODE_SHL;
        sin_r1 = 1'b1;
        step();
        n_checks++;
        if (q1 !== 1'b1 || full1 !== 1'b1 || cnt1 !== 1'b1) begin
            n_fail++; $display("FAIL w1_shl got q=%b cnt=%b full=%b exp q=1 cnt=1 full=1", q1, cnt1, full1);
        end
        mode1 = MODE_ROTL;
        step();
        n_checks++;
        if (q1 !== 1'b1 || full1 !== 1'b1) begin
            n_fail++; $display("FAIL w1_rotl got q=%b full=%b exp q=1 full=1", q1, full1);
        end
        mode1  = MODE_SHR;
        sin_l1 = 1'b0;
        step();
        n_checks++;
        if (q1 !== 1'b0 || qn1 !== 1'b1) begin
            n_fail++; $display("FAIL w1_shr got q=%b qn=%b exp q=0 qn=1", q1, qn1);
        end
        mode1 = MODE_LOAD;
        d1    = 1'b1;
        step();
        n_checks++;
        if (q1 !== 1'b1 || cnt1 !== 1'b0 || full1 !== 1'b0) begin
            n_fail++; $display("FAIL w1_load got q=%b cnt=%b full=%b exp q=1 cnt=0 full=0", q1, cnt1, full1);
        end
        mode1 = MODE_ROTR;
        step();
        n_checks++;
        if (q1 !== 1'b1 || cnt1 !== 1'b1) begin
            n_fail++; $display("FAIL w1_rotr got q=%b cnt=%b exp q=1 cnt=1", q1, cnt1);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        en       = 1'b0;
        mode     = MODE_HOLD;
        d        = 8'h00;
        sin_r    = 1'b0;
        sin_l    = 1'b0;
        en1      = 1'b0;
        mode1    = MODE_HOLD;
        d1       = 1'b0;
        sin_r1   = 1'b0;
        sin_l1   = 1'b0;

        test_reset();
        test_shl_count();
        test_serial();
        test_gating();
        test_async_reset();
        test_parity();
        test_width1();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
